// File: rtl/addseq_ctrl.sv
// Multi-cycle W-bit add/subtract controller that time-shares one external
// combinational 8-bit adder slice, processing one byte per clock, LSB first.
module addseq_ctrl #(
  parameter int NBYTES = 4,
  parameter int CW     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [8*NBYTES-1:0]   in1,
  input  logic [8*NBYTES-1:0]   in2,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carryout,
  output logic                  overflow,
  output logic                  zero,
  output logic [7:0]            slc_a,
  output logic [7:0]            slc_b,
  output logic                  slc_cin,
  input  logic [7:0]            slc_sum,
  input  logic                  slc_cout
);

  localparam int W = 8 * NBYTES;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Every byte except the top one, which is arriving from the slice on the final edge.
  localparam logic [W-1:0] LOW_MASK = {{8{1'b0}}, {(W-8){1'b1}}};

  logic [1:0]    state;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          last;

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign last  = (cnt == CW'(NBYTES - 1));

  always_comb begin
    slc_a   = '0;
    slc_b   = '0;
    slc_cin = 1'b0;
    if (state == RUN) begin
      slc_cin = carry;
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (cnt == CW'(i)) begin
          slc_a = opa[i*8 +: 8];
          slc_b = opb[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opa      <= '0;
      opb      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa      <= in1;
            opb      <= sub ? ~in2 : in2;
            carry    <= sub;
            cnt      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NBYTES; i++) begin
            if (cnt == CW'(i)) result[i*8 +: 8] <= slc_sum;
          end
          carry <= slc_cout;
          cnt   <= cnt + CW'(1);
          if (last) begin
            carryout <= slc_cout;
            overflow <= slc_a[7] ^ slc_b[7] ^ slc_sum[7] ^ slc_cout;
            // Equivalent to testing the full result once the top byte has landed.
            zero     <= ((result & LOW_MASK) == '0) && (slc_sum == 8'h00);
            state    <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addseq_ctrl.sv
// Scoreboard bench for addseq_ctrl with a behavioural 8-bit slice; expected
// results are hand-computed and queued at issue, popped on each done pulse.
module tb_addseq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        ready, busy, done;
  logic [31:0] result;
  logic        carryout, overflow, zero;
  logic [7:0]  slc_a, slc_b, slc_sum;
  logic        slc_cin, slc_cout;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  assign {slc_cout, slc_sum} = {1'b0, slc_a} + {1'b0, slc_b} + {8'h00, slc_cin};

  addseq_ctrl #(.NBYTES(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .in1(in1), .in2(in2),
    .ready(ready), .busy(busy), .done(done), .result(result),
    .carryout(carryout), .overflow(overflow), .zero(zero),
    .slc_a(slc_a), .slc_b(slc_b), .slc_cin(slc_cin),
    .slc_sum(slc_sum), .slc_cout(slc_cout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("result_flags", 64'({result, carryout, overflow, zero}), 64'(e));
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic push, input exp_t e);
    in1 = a; in2 = b; sub = s; start = 1'b1;
    if (push) sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output logic [15:0] mask);
    cyc = 1;
    mask = '0;
    mask[1] = slc_cin;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc < 16) mask[cyc] = slc_cin;
    end
    if (!done) check("done_timeout", 64'(done), 64'(1));
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input exp_t e, output int cyc, output logic [15:0] mask);
    issue(a, b, s, 1'b1, e);
    wait_done(cyc, mask);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          cyc;
    logic [15:0] mask;

    @(negedge clk);
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_outputs", 64'({busy, done, result, carryout, overflow, zero, slc_a, slc_b, slc_cin}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, '{32'h0000_0100, 1'b0, 1'b0, 1'b0}, cyc, mask);
    check("latency", 64'(cyc), 64'(5));
    check("cin_byte1_only", 64'(mask), 64'(16'h0004));
    check("done_ready_busy", 64'({ready, busy}), 64'(0));
    @(negedge clk);

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}, cyc, mask);
    @(negedge clk);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}, cyc, mask);
    @(negedge clk);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}, cyc, mask);
    @(negedge clk);
    run_op(32'h0000_0007, 32'h0000_0007, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}, cyc, mask);
    @(negedge clk);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}, cyc, mask);

    // Start raised during DONE: must wait until IDLE to be accepted.
    in1 = 32'h0000_0003; in2 = 32'h0000_0004; sub = 1'b0; start = 1'b1;
    sbq.push_back('{32'h0000_0007, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    check("idle_after_done", 64'({ready, busy}), 64'(2'b10));
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, mask);
    check("done_cycle_start_latency", 64'(cyc), 64'(5));
    @(negedge clk);

    // Starts pulsed throughout RUN are ignored.
    issue(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b1, '{32'h1122_3344, 1'b0, 1'b0, 1'b0});
    for (int k = 0; k < 4; k++) begin
      check("ready_in_run", 64'({ready, busy}), 64'(2'b01));
      in1 = 32'hDEAD_0000 + 32'(k); in2 = 32'h0BAD_F00D; sub = 1'b1; start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    check("done_after_run", 64'(done), 64'(1));
    @(negedge clk);
    check("no_requeue", 64'({ready, busy}), 64'(2'b10));

    // Reset after byte 1 has been processed.
    issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_ready", 64'(ready), 64'(1));
    check("midrun_rst_outputs", 64'({busy, done, result, carryout, overflow, zero, slc_a, slc_b, slc_cin}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_done_after_abort", 64'({ready, busy}), 64'(2'b10));

    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, '{32'h2345_6789, 1'b0, 1'b0, 1'b0}, cyc, mask);
    check("fresh_latency", 64'(cyc), 64'(5));
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
